// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: entry layout, FSM states and fetch granularity.
package brq_pkg;

  localparam int INSTR_BYTES = 4;
  // Entry storage width; the top-level bit_width must not exceed it.
  localparam int BRQ_PC_W    = 32;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } brq_state_t;

  typedef struct packed {
    logic [BRQ_PC_W-1:0] pc;
    logic                predTaken;
    logic [BRQ_PC_W-1:0] predTarget;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-facing bundle of the branch resolve queue.
interface branch_resolve_queue_if #(
  parameter int bit_width = 32,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                 push;
  logic [bit_width-1:0] pushPc;
  logic                 pushPredTaken;
  logic [bit_width-1:0] pushPredTarget;
  logic                 full;
  logic                 resolve;
  logic                 resolveTaken;
  logic [bit_width-1:0] resolveTarget;
  logic                 update;
  logic [bit_width-1:0] updatePc;
  logic                 reality;
  logic                 mispredict;
  logic [bit_width-1:0] redirectPc;
  logic [CW-1:0]        count;
  logic                 underflowErr;

  modport master (
    output push, pushPc, pushPredTaken, pushPredTarget,
    output resolve, resolveTaken, resolveTarget,
    input  full, update, updatePc, reality, mispredict, redirectPc, count, underflowErr
  );

  modport slave (
    input  push, pushPc, pushPredTaken, pushPredTarget,
    input  resolve, resolveTaken, resolveTarget,
    output full, update, updatePc, reality, mispredict, redirectPc, count, underflowErr
  );

endinterface

// File: rtl/branch_resolve_queue_fifo.sv
// Circular in-order storage for predicted branches; flush empties the queue behind a popped head.
module brq_fifo
  import brq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  brq_entry_t    push_entry,
  input  logic          pop,
  input  logic          flush,
  output brq_entry_t    head_entry,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  brq_entry_t    mem_q [DEPTH];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) head_d = head_q + 1'b1;
    // Flush always accompanies the pop of the mispredicted head.
    if (flush) begin
      tail_d  = head_q + 1'b1;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= push_entry;
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;
  assign full       = (count_q == CW'(DEPTH));

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks predicted branches oldest-first, trains the predictor and redirects fetch on mispredict.
//   state   | meaning
//   RUN     | normal push/resolve operation
//   RECOVER | one cycle after a redirect; pushes ignored, resolves count as underflow
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int bit_width = 32,
  parameter int DEPTH     = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  branch_resolve_queue_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  brq_entry_t           push_e, head_e;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full;
  logic [bit_width-1:0] head_pc, head_tgt, redirect_calc;
  logic                 run, pop, mis, push_ok;

  brq_state_t           state_q, state_d;
  logic                 update_q, update_d;
  logic [bit_width-1:0] update_pc_q, update_pc_d;
  logic                 reality_q, reality_d;
  logic                 mispredict_q, mispredict_d;
  logic [bit_width-1:0] redirect_pc_q, redirect_pc_d;
  logic                 underflow_q, underflow_d;

  always_comb begin
    push_e.pc         = BRQ_PC_W'(bus.pushPc);
    push_e.predTaken  = bus.pushPredTaken;
    push_e.predTarget = BRQ_PC_W'(bus.pushPredTarget);
    head_pc           = bit_width'(head_e.pc);
    head_tgt          = bit_width'(head_e.predTarget);
    redirect_calc     = bus.resolveTaken ? bus.resolveTarget
                                         : head_pc + bit_width'(INSTR_BYTES);
  end

  always_comb begin
    run     = (state_q == RUN);
    pop     = bus.resolve & run & (fifo_count != '0);
    mis     = pop & ((head_e.predTaken != bus.resolveTaken) |
                     (head_e.predTaken & bus.resolveTaken & (head_tgt != bus.resolveTarget)));
    push_ok = run & bus.push & ~fifo_full & ~mis;

    state_d       = mis ? RECOVER : RUN;
    update_d      = pop;
    update_pc_d   = pop ? head_pc : update_pc_q;
    reality_d     = pop ? bus.resolveTaken : reality_q;
    mispredict_d  = mis;
    redirect_pc_d = mis ? redirect_calc : redirect_pc_q;
    underflow_d   = underflow_q | (bus.resolve & ~pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      update_q      <= 1'b0;
      update_pc_q   <= '0;
      reality_q     <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      update_q      <= update_d;
      update_pc_q   <= update_pc_d;
      reality_q     <= reality_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      underflow_q   <= underflow_d;
    end
  end

  brq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_ok),
    .push_entry (push_e),
    .pop        (pop),
    .flush      (mis),
    .head_entry (head_e),
    .count      (fifo_count),
    .full       (fifo_full)
  );

  assign bus.full         = fifo_full;
  assign bus.count        = fifo_count;
  assign bus.update       = update_q;
  assign bus.updatePc     = update_pc_q;
  assign bus.reality      = reality_q;
  assign bus.mispredict   = mispredict_q;
  assign bus.redirectPc   = redirect_pc_q;
  assign bus.underflowErr = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: a queue model predicts each resolve's outcome.
module tb_branch_resolve_queue;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic        reality;
    logic        mis;
    logic [31:0] redirect;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  ent_t mq[$];
  res_t exp_q[$];
  logic m_rec = 1'b0;
  logic m_uflow = 1'b0;

  branch_resolve_queue_if #(.bit_width(32), .DEPTH(4)) bus();

  branch_resolve_queue #(.bit_width(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    res_t x;
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("full", 32'(bus.full), 32'(mq.size() == 4));
    chk("underflowErr", 32'(bus.underflowErr), 32'(m_uflow));
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("update", 32'(bus.update), 32'd1);
      chk("updatePc", bus.updatePc, x.pc);
      chk("reality", 32'(bus.reality), 32'(x.reality));
      chk("mispredict", 32'(bus.mispredict), 32'(x.mis));
      if (x.mis) chk("redirectPc", bus.redirectPc, x.redirect);
    end else begin
      chk("no_update", 32'(bus.update), 32'd0);
      chk("no_mispredict", 32'(bus.mispredict), 32'd0);
    end
  endtask

  task automatic cyc(input logic p, input logic [31:0] ppc, input logic ppt, input logic [31:0] ptgt,
                     input logic r, input logic rt, input logic [31:0] rtgt);
    ent_t e;
    res_t x;
    logic run, pre_full, popv, mis;
    @(negedge clk);
    bus.push = p; bus.pushPc = ppc; bus.pushPredTaken = ppt; bus.pushPredTarget = ptgt;
    bus.resolve = r; bus.resolveTaken = rt; bus.resolveTarget = rtgt;
    run = !m_rec;
    pre_full = (mq.size() == 4);
    popv = r && run && (mq.size() > 0);
    mis = 1'b0;
    if (popv) begin
      e = mq.pop_front();
      mis = (e.pt != rt) || (e.pt && rt && (e.tgt != rtgt));
      x.pc = e.pc; x.reality = rt; x.mis = mis;
      x.redirect = rt ? rtgt : e.pc + 32'd4;
      exp_q.push_back(x);
    end else if (r) begin
      m_uflow = 1'b1;
    end
    if (mis) mq.delete();
    if (run && p && !pre_full && !mis) begin
      e.pc = ppc; e.pt = ppt; e.tgt = ptgt;
      mq.push_back(e);
    end
    m_rec = mis;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic psh(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    cyc(1'b1, pc, pt, tgt, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rsv(input logic rt, input logic [31:0] rtgt);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rt, rtgt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.push = 1'b1; bus.pushPc = 32'hDEAD0000; bus.pushPredTaken = 1'b1; bus.pushPredTarget = 32'h0;
    bus.resolve = 1'b1; bus.resolveTaken = 1'b0; bus.resolveTarget = 32'h0;
    @(posedge clk);
    #1;
    mq.delete(); exp_q.delete(); m_rec = 1'b0; m_uflow = 1'b0;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_update", 32'(bus.update), 32'd0);
    chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
    chk("rst_underflowErr", 32'(bus.underflowErr), 32'd0);
    chk("rst_updatePc", bus.updatePc, 32'd0);
    chk("rst_redirectPc", bus.redirectPc, 32'd0);
    chk("rst_reality", 32'(bus.reality), 32'd0);
    rst_n = 1'b1;
    bus.push = 1'b0; bus.resolve = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, tgt;
    logic        pt, rt, r, p;
    bus.push = 1'b0; bus.pushPc = '0; bus.pushPredTaken = 1'b0; bus.pushPredTarget = '0;
    bus.resolve = 1'b0; bus.resolveTaken = 1'b0; bus.resolveTarget = '0;
    do_reset();

    // correct taken prediction
    psh(32'h100, 1'b1, 32'h200);
    chk("t1_count_after_push", 32'(bus.count), 32'd1);
    rsv(1'b1, 32'h200);
    chk("t1_updatePc", bus.updatePc, 32'h100);
    chk("t1_count_after_resolve", 32'(bus.count), 32'd0);
    idle();

    // direction mispredicts both ways, then wrong target
    psh(32'h40, 1'b0, 32'h0);
    rsv(1'b1, 32'h80);
    chk("t2_redirect_taken", bus.redirectPc, 32'h80);
    idle();
    psh(32'h44, 1'b1, 32'h300);
    rsv(1'b0, 32'h0);
    chk("t2_redirect_fallthrough", bus.redirectPc, 32'h48);
    idle();
    psh(32'h500, 1'b1, 32'h600);
    rsv(1'b1, 32'h700);
    chk("t2_redirect_target", bus.redirectPc, 32'h700);
    idle();

    // fill, overfill, drain in order
    for (int i = 0; i < 4; i++) psh(32'h1000 + 32'(i * 16), i[0], 32'h2000 + 32'(i));
    chk("t3_full", 32'(bus.full), 32'd1);
    psh(32'hBAD0, 1'b0, 32'h0);
    chk("t3_count_after_drop", 32'(bus.count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      rsv(i[0], 32'h2000 + 32'(i));
      chk("t3_order", bus.updatePc, 32'h1000 + 32'(i * 16));
    end
    idle();

    // mispredict with same-cycle push, then RECOVER push ignored
    psh(32'h3000, 1'b0, 32'h0);
    psh(32'h3004, 1'b0, 32'h0);
    psh(32'h3008, 1'b0, 32'h0);
    cyc(1'b1, 32'h300C, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4000);
    chk("t4_flush_count", 32'(bus.count), 32'd0);
    psh(32'h5000, 1'b0, 32'h0);
    chk("t4_recover_push_ignored", 32'(bus.count), 32'd0);
    psh(32'h5004, 1'b0, 32'h0);
    chk("t4_push_after_recover", 32'(bus.count), 32'd1);
    rsv(1'b0, 32'h0);
    idle();

    // underflow is sticky until reset; reset discards in-flight entries
    rsv(1'b1, 32'h0);
    idle();
    idle();
    chk("t5_uflow_sticky", 32'(bus.underflowErr), 32'd1);
    psh(32'h6000, 1'b1, 32'h6100);
    psh(32'h6004, 1'b1, 32'h6100);
    do_reset();
    idle();
    idle();

    // fall-through wraps the address space
    psh(32'hFFFFFFFC, 1'b1, 32'h10);
    rsv(1'b0, 32'h0);
    chk("t6_redirect_wrap", bus.redirectPc, 32'h0);
    idle();

    // pointer wrap, separate and overlapped push/resolve
    for (int i = 0; i < 10; i++) begin
      psh(32'h7000 + 32'(i * 4), 1'b1, 32'h8000 + 32'(i));
      rsv(1'b1, 32'h8000 + 32'(i));
      chk("t7_wrap_updatePc", bus.updatePc, 32'h7000 + 32'(i * 4));
    end
    psh(32'h9000, 1'b0, 32'h0);
    for (int i = 1; i < 6; i++) cyc(1'b1, 32'h9000 + 32'(i * 4), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    rsv(1'b0, 32'h0);
    idle();

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      p = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      pc = $urandom & 32'hFFFF_FFFC;
      pt = 1'($urandom_range(0, 1));
      tgt = $urandom & 32'hFFFF_FFFC;
      rt = 1'b0;
      if (mq.size() > 0) begin
        rt = ($urandom_range(0, 3) == 0) ? !mq[0].pt : mq[0].pt;
        tgt = mq[0].tgt;
      end
      cyc(p, pc, pt, $urandom & 32'hFFFF_FFFC, r, rt,
          ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : tgt);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
